// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the memory-mapped UART peripheral:
//   - register word offsets relative to BASE_ADDR (TXD, RXD, CON)
//   - CON register bit positions
//   - TX and RX state machine encodings
//   - depth of the optional RX FIFO (used when UART_RX_FIFO_EN is defined)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam logic [31:0] OFS_TXD = 32'd0;
    localparam logic [31:0] OFS_RXD = 32'd4;
    localparam logic [31:0] OFS_CON = 32'd8;

    localparam int CON_TXIE   = 0;
    localparam int CON_RXIE   = 1;
    localparam int CON_RXRDY  = 2;
    localparam int CON_TXDONE = 3;
    localparam int CON_TXBUSY = 4;
    localparam int CON_OVR    = 5;
    localparam int CON_FERR   = 6;

    localparam int RX_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// Serial receiver: 2-flop synchronizer, start-bit qualification, 8 data bits
// LSB first, one stop-bit sample.
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   rx_in     raw serial input (asynchronous to clk)
//   rx_valid  one-cycle pulse: rx_byte holds a frame with a good stop bit
//   rx_byte   received byte
//   rx_ferr   one-cycle pulse: stop bit sampled low, byte discarded
// -----------------------------------------------------------------------------
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_ferr
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    logic      sync1_q, sync2_q, prev_q;
    rx_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        rx_s, fall;

    assign rx_s = sync2_q;
    // Edge on the synchronized line; prev_q tracks it every cycle so a line
    // that stays low after a framing error never retriggers a frame.
    assign fall = prev_q & ~rx_s;
    assign rx_byte = shift_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        rx_valid = 1'b0;
        rx_ferr  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (fall) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // Mid-start-bit re-sample: a high line here was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d    = '0;
                    state_d  = RX_IDLE;
                    rx_valid = rx_s;
                    rx_ferr  = ~rx_s;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
            prev_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/uart_periph.sv
// -----------------------------------------------------------------------------
// uart_periph
// Memory-mapped UART on the CPU data bus. Registers (word addresses):
//   BASE_ADDR+0 TXD (write-only), +4 RXD (read-only, pops), +8 CON.
// Ports:
//   clk, reset (asynchronous active-low)
//   rd, wr, addr[31:0], wdata[31:0]  bus strobes/address/write data
//   rdata[31:0]                      combinational read data, 0 when unselected
//   uart_rx / uart_tx                serial in / out (tx idles high)
//   irq                              (TXIE & TXDONE) | (RXIE & RXRDY)
// Build option: UART_RX_FIFO_EN selects a 4-entry RX FIFO instead of a single
// holding register.
// -----------------------------------------------------------------------------
module uart_periph
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0018,
    parameter int          CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    localparam logic [31:0] TXD_ADDR = BASE_ADDR + OFS_TXD;
    localparam logic [31:0] RXD_ADDR = BASE_ADDR + OFS_RXD;
    localparam logic [31:0] CON_ADDR = BASE_ADDR + OFS_CON;
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    logic sel_txd, sel_rxd, sel_con, con_rd;
    logic unused_bits;

    assign sel_txd = (addr[31:2] == TXD_ADDR[31:2]);
    assign sel_rxd = (addr[31:2] == RXD_ADDR[31:2]);
    assign sel_con = (addr[31:2] == CON_ADDR[31:2]);
    assign con_rd  = rd & sel_con;
    assign unused_bits = ^{addr[1:0], wdata[31:8]};

    // ---------------- TX ----------------
    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d;
    logic        tx_done_set, txbusy;

    assign txbusy  = (tx_state_q != TX_IDLE);
    assign uart_tx = tx_q;

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_done_set = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (wr && sel_txd) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = wdata[7:0];
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d    = '0;
                    tx_state_d  = TX_IDLE;
                    tx_done_set = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // Line level follows the next state so uart_tx is a clean flop output.
        case (tx_state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = tx_shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // ---------------- RX core ----------------
    logic       rx_valid, rx_ferr;
    logic [7:0] rx_byte;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .reset   (reset),
        .rx_in   (uart_rx),
        .rx_valid(rx_valid),
        .rx_byte (rx_byte),
        .rx_ferr (rx_ferr)
    );

    // ---------------- RX buffer ----------------
    logic       rxrdy, rx_full, rx_pop, rx_push, rx_ovr_set;
    logic [7:0] rx_head;

    // A pop in the same cycle frees the slot, so a push into a full buffer
    // is only an overrun when nothing is being read out.
    assign rx_pop     = rd & sel_rxd & rxrdy;
    assign rx_push    = rx_valid & (~rx_full | rx_pop);
    assign rx_ovr_set = rx_valid & rx_full & ~rx_pop;

`ifdef UART_RX_FIFO_EN
    logic [7:0] mem_q [RX_FIFO_DEPTH];
    logic [1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [2:0] count_q, count_d;
    logic [RX_FIFO_DEPTH-1:0] entry_we;

    assign rxrdy   = (count_q != 3'd0);
    assign rx_full = (count_q == 3'(RX_FIFO_DEPTH));
    assign rx_head = mem_q[rptr_q];

    for (genvar gi = 0; gi < RX_FIFO_DEPTH; gi++) begin : g_entry_we
        assign entry_we[gi] = rx_push & (wptr_q == 2'(gi));
    end

    always_comb begin
        wptr_d  = wptr_q + {1'b0, rx_push};
        rptr_d  = rptr_q + {1'b0, rx_pop};
        count_d = count_q + {2'b00, rx_push} - {2'b00, rx_pop};
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < RX_FIFO_DEPTH; i++) begin
            if (entry_we[i]) begin
                mem_q[i] <= rx_byte;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
`else
    logic [7:0] hold_q, hold_d;
    logic       rxrdy_q, rxrdy_d;

    assign rxrdy   = rxrdy_q;
    assign rx_full = rxrdy_q;
    assign rx_head = hold_q;

    always_comb begin
        hold_d  = hold_q;
        rxrdy_d = rxrdy_q;
        if (rx_push) begin
            hold_d  = rx_byte;
            rxrdy_d = 1'b1;
        end else if (rx_pop) begin
            rxrdy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q  <= '0;
            rxrdy_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            rxrdy_q <= rxrdy_d;
        end
    end
`endif

    // ---------------- CON ----------------
    logic        txie_q, txie_d, rxie_q, rxie_d;
    logic        txdone_q, txdone_d, ovr_q, ovr_d, ferr_q, ferr_d;
    logic [31:0] con_val;

    always_comb begin
        txie_d = txie_q;
        rxie_d = rxie_q;
        if (wr && sel_con) begin
            txie_d = wdata[CON_TXIE];
            rxie_d = wdata[CON_RXIE];
        end
        // Set events take priority over the clear-on-read.
        txdone_d = tx_done_set | (txdone_q & ~con_rd);
        ovr_d    = rx_ovr_set  | (ovr_q    & ~con_rd);
        ferr_d   = rx_ferr     | (ferr_q   & ~con_rd);
    end

    always_comb begin
        con_val             = '0;
        con_val[CON_TXIE]   = txie_q;
        con_val[CON_RXIE]   = rxie_q;
        con_val[CON_RXRDY]  = rxrdy;
        con_val[CON_TXDONE] = txdone_q;
        con_val[CON_TXBUSY] = txbusy;
        con_val[CON_OVR]    = ovr_q;
        con_val[CON_FERR]   = ferr_q;
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_rxd) begin
                rdata = {24'h0, rxrdy ? rx_head : 8'h00};
            end else if (sel_con) begin
                rdata = con_val;
            end
        end
    end

    assign irq = (txie_q & txdone_q) | (rxie_q & rxrdy);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            txie_q     <= 1'b0;
            rxie_q     <= 1'b0;
            txdone_q   <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            txie_q     <= txie_d;
            rxie_q     <= rxie_d;
            txdone_q   <= txdone_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
        end
    end

endmodule
